rx_os_consensus: RTL and testbench
==================================

# rx_os_consensus

Parametrised ordered-set qualification engine for the receive-side LTSSM. It takes a configurable number of lanes, each with its own 128-bit ordered set. Per lane, it counts consecutive identical ordered sets that match the expected type and optional link/lane number. When every active lane reaches a programmable count, or a programmable timeout expires, it reports once and returns the agreed link number, rate ID and upconfigure bit. It sits between the per-lane ordered-set decoders and the master Rx LTSSM, and replaces fixed 16-lane checker/counter/comparator arrays.

## Interface
- LANES, 16: number of lane channels (1..32).
- CNT_W, 5: width of per-lane consecutive-count counters; counters saturate at 2^CNT_W-1.
- TMO_W, 24: width of timeout counter.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; arms a new qualification round (sampled in any state).
- laneMask  in  LANES  active lanes; sampled at start.
- expType  in  8  required byte 0 of ordered set (e.g. 8'h1E TS1, 8'h2D TS2).
- checkLink  in  1  require OS byte 1 == linkNumber.
- checkLane  in  1  require OS byte 2 == lane index.
- linkNumber  in  8  expected link number.
- targetCount  in  CNT_W  consecutive identical OSs required per lane (0 treated as 1).
- timeoutCycles  in  TMO_W  cycles allowed after start; 0 disables timeout.
- orderedSets  in  128*LANES  lane i in bits [128*i+127:128*i]; byte k = bits [8k+7:8k] within lane.
- validOrderedSets  in  LANES  per-lane OS strobe.
- finish  out  1  one-cycle pulse ending a round.
- timedOut  out  1  valid with finish; round ended by timeout.
- consistent  out  1  valid with finish; all qualified active lanes agree on bytes 1 and 4.
- qualifiedLanes  out  LANES  live per-lane qualified flags.
- rateId  out  8  byte 4 of reference lane's last OS, registered at finish.
- linkNumberOut  out  8  byte 1 of reference lane's last OS, registered at finish.
- upConfigureCapability  out  1  byte 4 bit 6 of reference lane, registered at finish.

## Operation
- Reset: FSM IDLE; all counters, qualifiedLanes, finish, timedOut, consistent, rateId, linkNumberOut, upConfigureCapability = 0.
- FSM states:
  - IDLE: wait for start.
  - COLLECT: count per lane.
  - DONE: assert finish for one cycle, then go to IDLE.
- start in any state (including COLLECT/DONE): clear all lane counters, stored OSs and qualified flags; latch laneMask; load the timer; enter COLLECT next cycle. start has priority over every other event.
- Per lane in COLLECT, on validOrderedSets[i]:
  - An OS matches when byte0==expType and it passes the enabled link and lane checks.
  - Match and identical (all 128 bits) to stored previous OS: counter+1, saturating.
  - Match but different from stored OS: counter=1.
  - Non-match: counter=0.
  - The OS is stored in all three cases.
- qualifiedLanes[i] = laneMask[i] & (counter >= max(targetCount,1)). Inactive lanes are never counted and read 0.
- Reference lane = lowest-index lane set in latched laneMask.
- Success: all masked lanes qualified → DONE with timedOut=0.
- Timeout: the timer decrements each COLLECT cycle. On reaching 0 with success not met → DONE with timedOut=1.
- Success and timeout in the same cycle: success wins (timedOut=0).
- laneMask all-zero at start: DONE on the next cycle with timedOut=0 and consistent=0.
- consistent = 1 iff every masked lane is qualified and its stored bytes 1 and 4 equal the reference lane's. On timeout it is 0.
- Result registers (rateId, linkNumberOut, upConfigureCapability) load on entry to DONE and hold until the next DONE or reset.

## Timing
- OS sampled on cycle N → counter and qualifiedLanes updated at edge N+1.
- finish asserts the cycle after the final qualifying update, i.e. 2 edges after the last needed OS.
- Timer: with timeoutCycles=T, finish with timedOut=1 occurs T+1 cycles after the start edge if success is never reached.
- finish is always exactly one cycle wide; back-to-back rounds need a fresh start.
- reset mid-round aborts with no finish pulse.

## Test plan
- LANES=4, mask 4'hF, targetCount=8, all lanes send 8 identical TS1s (byte1=8'h05, byte4=8'h1E) → finish once, timedOut=0, consistent=1, linkNumberOut=8'h05, rateId=8'h1E.
- Lane 2 sends 5 identical OSs, one differing OS, then 8 identical OSs; other lanes qualify earlier → finish only after lane 2's 8th repeat; qualifiedLanes shows 4'b1011 before that.
- checkLink=1, linkNumber=8'h03, lane 1 carries byte1=8'h04 throughout, timeoutCycles=100 → finish at cycle 101 after start, timedOut=1, consistent=0.
- Masked lanes 0,2 qualify with byte1 8'h01 vs 8'h02 → finish, consistent=0, linkNumberOut=8'h01 (lane 0 is reference).
- start reasserted mid-COLLECT with counts at 6 → counters restart from 0; no finish before 8 new repeats.
- Success on the exact timeout cycle → timedOut=0; reset asserted during COLLECT → all outputs 0, no finish.

Source files
------------

// File: rtl/rx_os_consensus.sv
// rtl/rx_os_consensus.sv - multi-lane ordered-set qualification engine for the Rx LTSSM
//
// Counts consecutive identical, matching ordered sets on every active lane and
// reports once when all active lanes qualify or the round timer expires.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start                   arms a new round (any state, highest priority)
//   laneMask                active lanes, latched at start
//   expType                 required byte 0
//   checkLink / linkNumber  optional byte 1 check
//   checkLane               optional byte 2 == lane index check
//   targetCount             consecutive repeats needed per lane (0 acts as 1)
//   timeoutCycles           round timer load value, 0 disables the timer
//   orderedSets             128 bits per lane, lane i at [128*i +: 128]
//   validOrderedSets        per-lane ordered-set strobe
//   finish                  one-cycle end-of-round pulse
//   timedOut, consistent    round status, valid with finish
//   qualifiedLanes          live per-lane qualified flags
//   rateId, linkNumberOut,
//   upConfigureCapability   reference-lane fields captured on entry to DONE

module rx_os_consensus #(
    parameter int LANES = 16,
    parameter int CNT_W = 5,
    parameter int TMO_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LANES-1:0]     laneMask,
    input  logic [7:0]           expType,
    input  logic                 checkLink,
    input  logic                 checkLane,
    input  logic [7:0]           linkNumber,
    input  logic [CNT_W-1:0]     targetCount,
    input  logic [TMO_W-1:0]     timeoutCycles,
    input  logic [128*LANES-1:0] orderedSets,
    input  logic [LANES-1:0]     validOrderedSets,
    output logic                 finish,
    output logic                 timedOut,
    output logic                 consistent,
    output logic [LANES-1:0]     qualifiedLanes,
    output logic [7:0]           rateId,
    output logic [7:0]           linkNumberOut,
    output logic                 upConfigureCapability
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [LANES-1:0]        mask_q;
    logic [TMO_W-1:0]        timer;
    logic                    tmo_en;
    logic [CNT_W-1:0]        tgt_eff;
    logic [LANES-1:0][7:0]   lane_link;
    logic [LANES-1:0][7:0]   lane_rate;
    logic [IDX_W-1:0]        ref_idx;
    logic                    ref_valid;
    logic                    agree;
    logic                    all_qualified;
    logic                    timeout_hit;

    assign tgt_eff = (targetCount == '0) ? CNT_W'(1) : targetCount;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [127:0]     os;
            logic [127:0]     stored;
            logic [CNT_W-1:0] cnt;
            logic             match;

            assign os    = orderedSets[128*g +: 128];
            assign match = (os[7:0] == expType)
                        && (!checkLink || (os[15:8] == linkNumber))
                        && (!checkLane || (os[23:16] == 8'(g)));

            // Inactive lanes are frozen at their cleared value so they never qualify.
            always_ff @(posedge clk) begin
                if (reset || start) begin
                    cnt    <= '0;
                    stored <= '0;
                end else if (state == S_COLLECT && mask_q[g] && validOrderedSets[g]) begin
                    stored <= os;
                    if (!match) begin
                        cnt <= '0;
                    end else if (os != stored) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            assign qualifiedLanes[g] = mask_q[g] && (cnt >= tgt_eff);
            assign lane_link[g]      = stored[15:8];
            assign lane_rate[g]      = stored[39:32];
        end
    endgenerate

    // Reference lane is the lowest-index active lane.
    always_comb begin
        ref_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                ref_idx = IDX_W'(i);
            end
        end
    end

    assign ref_valid = |mask_q;

    always_comb begin
        agree = ref_valid;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[i] && ((lane_link[i] != lane_link[ref_idx]) ||
                              (lane_rate[i] != lane_rate[ref_idx]))) begin
                agree = 1'b0;
            end
        end
    end

    // An empty mask is vacuously all-qualified, which ends the round at once.
    assign all_qualified = &(qualifiedLanes | ~mask_q);
    assign timeout_hit   = tmo_en && (timer == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            mask_q                <= '0;
            timer                 <= '0;
            tmo_en                <= 1'b0;
            finish                <= 1'b0;
            timedOut              <= 1'b0;
            consistent            <= 1'b0;
            rateId                <= '0;
            linkNumberOut         <= '0;
            upConfigureCapability <= 1'b0;
        end else if (start) begin
            state  <= S_COLLECT;
            mask_q <= laneMask;
            timer  <= timeoutCycles;
            tmo_en <= (timeoutCycles != '0);
            finish <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    finish <= 1'b0;
                end
                S_COLLECT: begin
                    // Success is checked first so a tie with the timer reports success.
                    if (all_qualified || timeout_hit) begin
                        state                 <= S_DONE;
                        finish                <= 1'b1;
                        timedOut              <= !all_qualified;
                        consistent            <= all_qualified && agree;
                        rateId                <= ref_valid ? lane_rate[ref_idx] : 8'h00;
                        linkNumberOut         <= ref_valid ? lane_link[ref_idx] : 8'h00;
                        upConfigureCapability <= ref_valid && lane_rate[ref_idx][6];
                    end else if (tmo_en) begin
                        timer <= timer - TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    finish <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    finish <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_os_consensus.sv
// tb/tb_rx_os_consensus.sv - scoreboard bench for rx_os_consensus with four lanes

module tb_rx_os_consensus;

    localparam int LANES = 4;
    localparam int CNT_W = 5;
    localparam int TMO_W = 24;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [LANES-1:0]     laneMask;
    logic [7:0]           expType;
    logic                 checkLink;
    logic                 checkLane;
    logic [7:0]           linkNumber;
    logic [CNT_W-1:0]     targetCount;
    logic [TMO_W-1:0]     timeoutCycles;
    logic [128*LANES-1:0] orderedSets;
    logic [LANES-1:0]     validOrderedSets;
    logic                 finish;
    logic                 timedOut;
    logic                 consistent;
    logic [LANES-1:0]     qualifiedLanes;
    logic [7:0]           rateId;
    logic [7:0]           linkNumberOut;
    logic                 upConfigureCapability;

    rx_os_consensus #(.LANES(LANES), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .laneMask(laneMask),
        .expType(expType),
        .checkLink(checkLink),
        .checkLane(checkLane),
        .linkNumber(linkNumber),
        .targetCount(targetCount),
        .timeoutCycles(timeoutCycles),
        .orderedSets(orderedSets),
        .validOrderedSets(validOrderedSets),
        .finish(finish),
        .timedOut(timedOut),
        .consistent(consistent),
        .qualifiedLanes(qualifiedLanes),
        .rateId(rateId),
        .linkNumberOut(linkNumberOut),
        .upConfigureCapability(upConfigureCapability)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         to;
        bit         cons;
        bit         chk_res;
        logic [7:0] link;
        logic [7:0] rate;
        bit         up;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   start_edge = 0;

    function automatic logic [127:0] mk_os(input logic [7:0] t, input logic [7:0] l,
                                           input logic [7:0] ln, input logic [7:0] r,
                                           input logic [7:0] x);
        return {88'h0123456789ABCDEF012345, x, r, 8'h00, ln, l, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] t, input logic [7:0] l,
                           input logic [7:0] r, input logic [7:0] x);
        for (int i = 0; i < LANES; i++) begin
            orderedSets[128*i +: 128] = mk_os(t, l, 8'(i), r, x);
        end
    endtask

    task automatic cfg(input logic [7:0] t, input logic cl, input logic cla,
                       input logic [7:0] ln);
        expType    = t;
        checkLink  = cl;
        checkLane  = cla;
        linkNumber = ln;
    endtask

    task automatic do_start(input logic [LANES-1:0] m, input logic [CNT_W-1:0] tgt,
                            input logic [TMO_W-1:0] t, input logic [LANES-1:0] v);
        laneMask         = m;
        targetCount      = tgt;
        timeoutCycles    = t;
        validOrderedSets = v;
        start            = 1'b1;
        step();
        start_edge       = cyc;
        start            = 1'b0;
        validOrderedSets = '0;
    endtask

    task automatic expect_finish(input bit to, input bit cons, input bit chk,
                                 input logic [7:0] link, input logic [7:0] rate,
                                 input bit up, input int c);
        exp_t e;
        e.to = to; e.cons = cons; e.chk_res = chk;
        e.link = link; e.rate = rate; e.up = up; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending finishes, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) step();
    endtask

    task automatic check_q(input string name, input logic [LANES-1:0] exp_q);
        checks++;
        if (qualifiedLanes !== exp_q) begin
            errors++;
            $display("FAIL %s: qualifiedLanes got %b expected %b", name, qualifiedLanes, exp_q);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && finish === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish: got finish at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL finish_cycle: got %0d expected %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (timedOut !== e.to) begin
                        errors++;
                        $display("FAIL timedOut: got %b expected %b", timedOut, e.to);
                    end
                    checks++;
                    if (consistent !== e.cons) begin
                        errors++;
                        $display("FAIL consistent: got %b expected %b", consistent, e.cons);
                    end
                    if (e.chk_res) begin
                        checks++;
                        if (linkNumberOut !== e.link) begin
                            errors++;
                            $display("FAIL linkNumberOut: got %h expected %h", linkNumberOut, e.link);
                        end
                        checks++;
                        if (rateId !== e.rate) begin
                            errors++;
                            $display("FAIL rateId: got %h expected %h", rateId, e.rate);
                        end
                        checks++;
                        if (upConfigureCapability !== e.up) begin
                            errors++;
                            $display("FAIL upConfigure: got %b expected %b", upConfigureCapability, e.up);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({finish, timedOut, consistent, qualifiedLanes, rateId, linkNumberOut,
             upConfigureCapability} !== '0) begin
            errors++;
            $display("FAIL %s: got fin=%b to=%b cons=%b q=%b rate=%h link=%h up=%b expected all 0",
                     name, finish, timedOut, consistent, qualifiedLanes, rateId,
                     linkNumberOut, upConfigureCapability);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        check_all_zero("reset_state");
        reset = 1'b0;
        step();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        cfg(8'h1E, 1'b0, 1'b1, 8'h00);
        set_all(8'h1E, 8'h05, 8'h1E, 8'h00);
        do_start(4'hF, 5'd8, '0, '0);
        validOrderedSets = 4'hF;
        repeat (7) step();
        check_q("basic_q_after7", 4'b0000);
        expect_finish(1'b0, 1'b1, 1'b1, 8'h05, 8'h1E, 1'b0, cyc + 2);
        step();
        check_q("basic_q_after8", 4'b1111);
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_lane_restart();
        cfg(8'h1E, 1'b0, 1'b1, 8'h00);
        do_start(4'hF, 5'd8, '0, '0);
        validOrderedSets = 4'hF;
        for (int k = 1; k <= 14; k++) begin
            set_all(8'h1E, 8'h05, 8'h42, 8'h00);
            if (k == 6) orderedSets[256 +: 128] = mk_os(8'h1E, 8'h05, 8'h02, 8'h42, 8'h77);
            if (k == 14) expect_finish(1'b0, 1'b1, 1'b1, 8'h05, 8'h42, 1'b1, cyc + 2);
            step();
            if (k >= 8 && k <= 13) check_q("lane2_partial", 4'b1011);
        end
        check_q("lane2_full", 4'b1111);
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_timeout();
        cfg(8'h1E, 1'b1, 1'b1, 8'h03);
        set_all(8'h1E, 8'h03, 8'h1E, 8'h00);
        orderedSets[128 +: 128] = mk_os(8'h1E, 8'h04, 8'h01, 8'h1E, 8'h00);
        do_start(4'hF, 5'd8, 24'd100, '0);
        expect_finish(1'b1, 1'b0, 1'b1, 8'h03, 8'h1E, 1'b0, start_edge + 101);
        validOrderedSets = 4'hF;
        for (int k = 1; k <= 103; k++) begin
            step();
            if (k == 20) check_q("timeout_q", 4'b1101);
        end
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_inconsistent();
        cfg(8'h1E, 1'b0, 1'b1, 8'h00);
        set_all(8'h1E, 8'h01, 8'h1E, 8'h00);
        orderedSets[256 +: 128] = mk_os(8'h1E, 8'h02, 8'h02, 8'h1E, 8'h00);
        do_start(4'b0101, 5'd4, '0, '0);
        validOrderedSets = 4'hF;
        repeat (3) step();
        expect_finish(1'b0, 1'b0, 1'b1, 8'h01, 8'h1E, 1'b0, cyc + 2);
        step();
        check_q("inconsistent_q", 4'b0101);
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_restart();
        cfg(8'h2D, 1'b0, 1'b0, 8'h00);
        set_all(8'h2D, 8'h09, 8'h1E, 8'h00);
        do_start(4'hF, 5'd8, '0, '0);
        validOrderedSets = 4'hF;
        repeat (6) step();
        check_q("restart_before", 4'b0000);
        do_start(4'hF, 5'd8, '0, 4'hF);
        validOrderedSets = 4'hF;
        repeat (7) step();
        check_q("restart_after7", 4'b0000);
        expect_finish(1'b0, 1'b1, 1'b1, 8'h09, 8'h1E, 1'b0, cyc + 2);
        step();
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_tmo_tie();
        cfg(8'h1E, 1'b0, 1'b0, 8'h00);
        set_all(8'h1E, 8'h0A, 8'h55, 8'h00);
        do_start(4'hF, 5'd4, 24'd4, '0);
        validOrderedSets = 4'hF;
        repeat (3) step();
        expect_finish(1'b0, 1'b1, 1'b1, 8'h0A, 8'h55, 1'b1, start_edge + 5);
        step();
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_empty_mask();
        do_start(4'b0000, 5'd8, '0, '0);
        expect_finish(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, start_edge + 1);
        drain(10);
    endtask

    task automatic test_target_zero();
        cfg(8'h2D, 1'b0, 1'b1, 8'h00);
        set_all(8'h1E, 8'h00, 8'h00, 8'h00);
        orderedSets[128 +: 128] = mk_os(8'h2D, 8'h07, 8'h01, 8'h42, 8'h00);
        do_start(4'b0010, 5'd0, '0, '0);
        validOrderedSets = 4'b0010;
        expect_finish(1'b0, 1'b1, 1'b1, 8'h07, 8'h42, 1'b1, cyc + 2);
        step();
        validOrderedSets = '0;
        drain(10);
    endtask

    task automatic test_reset_mid();
        cfg(8'h1E, 1'b0, 1'b0, 8'h00);
        set_all(8'h1E, 8'h05, 8'h1E, 8'h00);
        do_start(4'hF, 5'd2, 24'd6, '0);
        validOrderedSets = 4'hF;
        step();
        reset = 1'b1;
        step();
        check_all_zero("reset_mid");
        reset = 1'b0;
        repeat (15) step();
        validOrderedSets = '0;
        check_all_zero("reset_mid_after");
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        laneMask         = '0;
        expType          = '0;
        checkLink        = 1'b0;
        checkLane        = 1'b0;
        linkNumber       = '0;
        targetCount      = '0;
        timeoutCycles    = '0;
        orderedSets      = '0;
        validOrderedSets = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_lane_restart();
        test_timeout();
        test_inconsistent();
        test_restart();
        test_tmo_tie();
        test_empty_mask();
        test_target_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
